crypto_sched_rr: RTL
====================

Name: crypto_sched_rr

Overview:
Round-robin scheduler that shares one dual-algorithm block cipher engine (AES/SM4, start/done pulse interface, 128-bit key/data) between NUM_CH requesters. Each request is a single 128-bit block. The scheduler accepts requests, issues exactly one operation at a time, and returns the result to the owning channel over a valid/ready response handshake. It sits between the DMA/packet channels and the crypto engine.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
DW, 128, block and key width
TMO_CYC, 256, watchdog limit in cycles while waiting for the engine (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel request accept; one-hot or zero
req_algo  in  NUM_CH  per-channel algorithm select: 0 = AES, 1 = SM4
req_key  in  NUM_CH*DW  per-channel key; channel i occupies bits [i*DW +: DW]
req_din  in  NUM_CH*DW  per-channel plaintext, same packing
rsp_valid  out  NUM_CH  per-channel response valid; one-hot or zero
rsp_ready  in  NUM_CH  per-channel response accept
rsp_data  out  DW  result, shared by all channels
rsp_err  out  1  result invalid due to timeout; qualified by rsp_valid
eng_algo_sel  out  1  to engine
eng_start  out  1  one-cycle start pulse to engine
eng_key  out  DW  to engine
eng_din  out  DW  to engine
eng_done  in  1  engine completion pulse
eng_dout  in  DW  engine result
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_CH)  channel currently owning the engine

Behaviour:
- Reset (async, rst_n low), all values 0 unless stated:
  - FSM = IDLE; req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0.
  - eng_start = 0; eng_algo_sel = 0; eng_key = 0; eng_din = 0; busy = 0; grant_id = 0.
  - last_grant = NUM_CH-1, so channel 0 has first priority.
- Reset mid-operation aborts the operation. A later eng_done from the aborted operation arrives in IDLE and is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Choose winner g = first i with req_valid[i], scanning from last_grant+1 with modulo-NUM_CH wrap.
  - req_ready[g] = 1 combinationally in the same cycle. The handshake completes on that edge.
  - On that edge, register g, req_algo[g], req_key[g], req_din[g] into grant_id, eng_algo_sel, eng_key, eng_din, then go to ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE: eng_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - On eng_done = 1, register eng_dout into rsp_data, clear rsp_err, go to RESP.
  - eng_done in any state other than WAIT is ignored, including a done in the same cycle as eng_start.
- RESP:
  - rsp_valid[grant_id] = 1, held with rsp_data stable until rsp_ready[grant_id] = 1.
  - On that edge: last_grant = grant_id, rsp_valid = 0, go to IDLE.
  - rsp_ready on other channels is ignored.
- Register stability: eng_algo_sel, eng_key and eng_din hold from the IDLE accept edge until the next accept. The engine's done/dout mux depends on algo_sel staying stable.
- Latency: with accept at edge T, eng_start is high during cycle T+1. With engine latency L (done L cycles after start), rsp_valid is high from the cycle after done. Minimum request-to-response is L+2 cycles.
- Throughput: at most one block in flight. There is at least one IDLE cycle between operations, so back-to-back operations are spaced L+3 cycles.
- Fairness: a channel that holds req_valid is granted within NUM_CH operations.
- Non-winning channels see req_ready = 0 and must hold their request.

Optional Feature:
CRYPTO_SCHED_TMO_EN
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TMO_CYC without eng_done: rsp_data = 0, rsp_err = 1, go to RESP. The channel is then released normally.
  - A late eng_done arriving after the timeout is ignored.
- Not defined: no counter; WAIT waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single request: ch1 sends AES, key 0x000102..0F, din 0x00112233445566778899AABBCCDDEEFF; engine model with L=12 returns FIPS-197 vector 0x69C4E0D86A7B0430D8CDB78070B4C55A -> req_ready[1] at T, eng_start at T+1, rsp_valid[1] at T+14, grant_id=1, rsp_err=0.
- Simultaneous request: ch0 and ch2 assert in the same cycle after reset -> ch0 served first, then ch2. eng_algo_sel follows each channel's req_algo (ch2 SM4=1) and stays stable until each response.
- Round-robin wrap: all four channels hold valid for 8 operations -> grant order 0,1,2,3,0,1,2,3; no channel starved.
- Response backpressure: rsp_ready[3] low for 20 cycles -> rsp_valid[3] and rsp_data stable for 20 cycles; no eng_start issued and ch0's pending request not accepted until release.
- Timeout (macro on, TMO_CYC=32): engine never asserts done -> rsp_valid with rsp_err=1 and rsp_data=0 after 32 WAIT cycles. A done injected at cycle 40 is ignored and the next request proceeds normally.
- Reset during WAIT: rst_n low for 2 cycles -> all outputs 0 immediately. A stale eng_done arriving afterwards produces no rsp_valid, and the next grant goes to ch0.

Source files
------------

// File: rtl/crypto_sched_rr_if.sv
// Channel-side bus of crypto_sched_rr: per-channel request and response handshakes.
// master = requester side, slave = scheduler side.
interface crypto_sched_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 128
);
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH-1:0]    req_algo;
  logic [NUM_CH*DW-1:0] req_key;
  logic [NUM_CH*DW-1:0] req_din;
  logic [NUM_CH-1:0]    rsp_valid;
  logic [NUM_CH-1:0]    rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;

  modport master (
    output req_valid, req_algo, req_key, req_din, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_algo, req_key, req_din, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/crypto_sched_rr.sv
// Round-robin scheduler sharing one AES/SM4 block engine between NUM_CH requesters.
// Optional engine watchdog is enabled by defining CRYPTO_SCHED_TMO_EN.
module crypto_sched_rr #(
  parameter int NUM_CH  = 4,
  parameter int DW      = 128,
  parameter int TMO_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  crypto_sched_rr_if.slave          ch,
  output logic                      eng_algo_sel,
  output logic                      eng_start,
  output logic [DW-1:0]             eng_key,
  output logic [DW-1:0]             eng_din,
  input  logic                      eng_done,
  input  logic [DW-1:0]             eng_dout,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] grant_id
);

  // state | meaning
  // IDLE  | arbitrate; winner's req_ready is driven combinationally
  // ISSUE | one-cycle eng_start pulse
  // WAIT  | wait for eng_done (or watchdog expiry)
  // RESP  | hold rsp_valid to the owner until its rsp_ready

  localparam int IDW = $clog2(NUM_CH);
  localparam logic [IDW:0] NCH = (IDW+1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [IDW-1:0]    last_grant;
  logic [IDW-1:0]    win_id;
  logic              win_found;
  logic [NUM_CH-1:0] rsp_valid_q;
  logic [DW-1:0]     rsp_data_q;

  if (NUM_CH < 2 || NUM_CH > 8 || DW < 1 || TMO_CYC < 1 || TMO_CYC > 65536) begin : g_param_check
    $error("crypto_sched_rr: parameter out of range");
  end

  // Scan from last_grant+1 with wrap; first requester found wins.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    sum       = '0;
    cand      = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sum = {1'b0, last_grant} + (IDW+1)'(k);
      if (sum >= NCH) sum = sum - NCH;
      cand = sum[IDW-1:0];
      if (!win_found && ch.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    ch.req_ready = '0;
    if (state == IDLE && win_found) ch.req_ready[win_id] = 1'b1;
  end

`ifdef CRYPTO_SCHED_TMO_EN
  logic        rsp_err_q;
  logic [15:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= IDW'(NUM_CH - 1);
      grant_id     <= '0;
      eng_algo_sel <= 1'b0;
      eng_key      <= '0;
      eng_din      <= '0;
      eng_start    <= 1'b0;
      busy         <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
`ifdef CRYPTO_SCHED_TMO_EN
      rsp_err_q    <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant_id     <= win_id;
            eng_algo_sel <= ch.req_algo[win_id];
            eng_key      <= ch.req_key[win_id*DW +: DW];
            eng_din      <= ch.req_din[win_id*DW +: DW];
            eng_start    <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CRYPTO_SCHED_TMO_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_data_q            <= eng_dout;
            rsp_valid_q[grant_id] <= 1'b1;
`ifdef CRYPTO_SCHED_TMO_EN
            rsp_err_q             <= 1'b0;
`endif
            state                 <= RESP;
          end
`ifdef CRYPTO_SCHED_TMO_EN
          else if (tmo_cnt == 16'(TMO_CYC - 1)) begin
            rsp_data_q            <= '0;
            rsp_err_q             <= 1'b1;
            rsp_valid_q[grant_id] <= 1'b1;
            state                 <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          // Only the owner's rsp_ready can release the engine.
          if (ch.rsp_ready[grant_id]) begin
            last_grant  <= grant_id;
            rsp_valid_q <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch.rsp_valid = rsp_valid_q;
  assign ch.rsp_data  = rsp_data_q;
`ifdef CRYPTO_SCHED_TMO_EN
  assign ch.rsp_err   = rsp_err_q;
`else
  assign ch.rsp_err   = 1'b0;
`endif

endmodule
